ask_rx_deframer: RTL and testbench

//  Receive side of the 2ASK link. Takes offset-binary carrier samples from the channel/ADC
//  and envelope-detects each bit by rectify-and-integrate over one symbol. Recovers the
//  16-bit word framed as: start bit '1', 16 data bits MSB first, stop bit '0'.

---
 rtl/ask_rx_deframer.sv | 153 +++++++++++++++
 tb/tb_ask_rx_deframer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ask_rx_deframer.sv
// 2ASK receive deframer: rectify-and-integrate bit decisions, start/16 data/stop framing.
// Optional ASK_RX_STATS_EN adds saturating good_cnt/err_cnt frame statistics outputs.
module ask_rx_deframer #(
    parameter int SPB    = 50,
    parameter int AMP_TH = 32,
    parameter int SUM_TH = 2000,
    parameter int ACC_W  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  ask_in,
    input  logic        in_valid,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
`ifdef ASK_RX_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int CNT_W = $clog2(SPB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [3:0]         r_bit_cnt;
    logic [15:0]        r_shift;

    logic [7:0]         w_mag;
    logic [ACC_W-1:0]   w_sum;
    logic               w_sym_end;
    logic               w_bit;
    logic               w_arm;
    logic               w_good_evt;
    logic               w_err_evt;
    logic               w_false_start;

    // x=0 yields 128, which still fits the 8-bit magnitude.
    assign w_mag     = (ask_in >= 8'd128) ? (ask_in - 8'd128) : (8'd128 - ask_in);
    assign w_sum     = r_acc + ACC_W'(w_mag);
    assign w_sym_end = in_valid && (r_state != S_IDLE) && (r_sample_cnt == CNT_W'(SPB - 1));
    assign w_bit     = (w_sum >= ACC_W'(SUM_TH));
    assign w_arm     = in_valid && (r_state == S_IDLE) && (w_mag >= 8'(AMP_TH));
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_state_nxt   = r_state;
        w_good_evt    = 1'b0;
        w_err_evt     = 1'b0;
        w_false_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sym_end) begin
                    if (w_bit) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_false_start = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_sym_end && (r_bit_cnt == 4'd15)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_sym_end) begin
                    w_state_nxt = S_IDLE;
                    w_good_evt  = ~w_bit;
                    w_err_evt   = w_bit;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc        <= '0;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_valid <= w_good_evt;
            frame_err  <= w_err_evt;
            if (w_arm) begin
                r_acc        <= ACC_W'(w_mag);
                r_sample_cnt <= CNT_W'(1);
            end else if (in_valid && (r_state != S_IDLE)) begin
                if (w_sym_end) begin
                    r_acc        <= '0;
                    r_sample_cnt <= '0;
                end else begin
                    r_acc        <= w_sum;
                    r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                end
            end
            if (w_sym_end && (r_state == S_START)) r_bit_cnt <= '0;
            if (w_sym_end && (r_state == S_DATA)) begin
                r_shift   <= {r_shift[14:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_good_evt) data_out <= r_shift;
        end
    end

`ifdef ASK_RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;

    // Counters move on the same edge that raises the matching pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_good_evt && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if ((w_err_evt || w_false_start) && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign good_cnt = r_good_cnt;
    assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_ask_rx_deframer.sv
// Self-checking bench for ask_rx_deframer: directed frames plus randomized words and gaps,
// compared against an expected-event queue built from the framing rules.
module tb_ask_rx_deframer;

    localparam int SPB = 50;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  ask_in;
    logic        in_valid;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;
`ifdef ASK_RX_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;
`endif

    ask_rx_deframer dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ask_in     (ask_in),
        .in_valid   (in_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef ASK_RX_STATS_EN
        ,
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #10 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [15:0] word;
        int unsigned at;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          both_seen = 1'b0;
    logic [15:0] model_dout = '0;
    int          model_good = 0;
    int          model_err  = 0;
    int          cos_tab[10] = '{100, 81, 31, -31, -81, -100, -81, -31, 31, 81};

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (data_valid && frame_err) both_seen = 1'b1;
            if (data_valid) obs_q.push_back('{1'b0, data_out, cyc});
            if (frame_err)  obs_q.push_back('{1'b1, data_out, cyc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] x);
        @(negedge sys_clk);
        in_valid = v;
        ask_in   = x;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 8'd128);
    endtask

    function automatic int sample_of(input bit b, input int s);
        return b ? 128 + cos_tab[s % 10] : 128;
    endfunction

    task automatic check_stats(input string tag);
`ifdef ASK_RX_STATS_EN
        chk({tag, "_good_cnt"}, 32'(good_cnt), 32'(model_good));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(model_err));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        ask_in   = 8'd128;
        repeat (2) @(negedge sys_clk);
        chk({tag, "_rst_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_rst_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_rst_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
        model_dout = '0;
        model_good = 0;
        model_err  = 0;
        check_stats({tag, "_rst"});
        sys_rst = 1'b0;
    endtask

    // mode 0: continuous samples; 1: one invalid cycle between samples; 2: random gaps.
    // abort_at >= 0 pulses reset just before that sample index instead of finishing.
    task automatic send_frame(input logic [15:0] word, input bit stop, input int mode,
                              input int abort_at);
        bit          bits[18];
        int          idx;
        int unsigned last;
        idx  = 0;
        last = 0;
        bits[0] = 1'b1;
        for (int i = 0; i < 16; i++) bits[i + 1] = word[15 - i];
        bits[17] = stop;
        for (int b = 0; b < 18; b++) begin
            for (int s = 0; s < SPB; s++) begin
                if (b * SPB + s == abort_at) begin
                    do_reset("abort");
                    return;
                end
                if (mode == 1 && idx > 0) drive(1'b0, 8'($urandom_range(0, 255)));
                else if (mode == 2)
                    while ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom_range(0, 255)));
                drive(1'b1, 8'(sample_of(bits[b], s)));
                idx++;
                last = cyc + 1;
            end
        end
        if (!stop) begin
            exp_q.push_back('{1'b0, word, last});
            model_dout = word;
            model_good++;
        end else begin
            exp_q.push_back('{1'b1, model_dout, last});
            model_err++;
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_kind"}, 32'(o.is_err), 32'(e.is_err));
            chk({tag, "_word"}, 32'(o.word), 32'(e.word));
            chk({tag, "_cycle"}, o.at, e.at);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_data_out"}, 32'(data_out), 32'(model_dout));
        chk({tag, "_busy_idle"}, 32'(busy), 32'h0);
        check_stats(tag);
    endtask

    initial begin
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        ask_in   = 8'd128;
        do_reset("init");
        idle(5);

        // Single frame, continuous samples
        send_frame(16'hABCD, 1'b0, 0, -1);
        idle(5);
        check_events("t1_abcd");

        // Back-to-back frames with no idle gap
        send_frame(16'hABCD, 1'b0, 0, -1);
        send_frame(16'h1234, 1'b0, 0, -1);
        idle(5);
        check_events("t2_b2b");

        // Short burst: false start after one symbol
        for (int s = 0; s < 5; s++) drive(1'b1, 8'(128 + cos_tab[s]));
        idle(44);
        chk("t3_busy_in_start", 32'(busy), 32'h1);
        drive(1'b1, 8'd128);
        @(negedge sys_clk);
        chk("t3_busy_after", 32'(busy), 32'h0);
        model_err++;
        idle(5);
        check_events("t3_false_start");

        // Stop bit '1' gives a framing error and keeps data_out
        send_frame(16'h00FF, 1'b1, 0, -1);
        idle(5);
        check_events("t4_stop_err");

        // Every other cycle invalid
        send_frame(16'h8001, 1'b0, 1, -1);
        idle(5);
        check_events("t5_gaps");

        // Reset in data bit 7, then a clean frame
        send_frame(16'hFFFF, 1'b0, 0, 8 * SPB + 25);
        idle(5);
        check_events("t6_abort");
        send_frame(16'h5A5A, 1'b0, 0, -1);
        idle(5);
        check_events("t6_after");

        // Random words, stop bits, gaps and idle spacing
        for (int r = 0; r < 6; r++) begin
            send_frame(16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
            idle($urandom_range(0, 30));
        end
        idle(5);
        check_events("rand");

        chk("never_both_pulses", 32'(both_seen), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
